// File: rtl/lshift_bill_mul.sv
// -----------------------------------------------------------------------------
// lshift_bill_mul
//   Sequential shift-and-add multiplier for the bill amount path:
//   amount = rate * units, computed over a fixed M iterations by shifting the
//   multiplicand left one bit per cycle and accumulating it whenever the
//   current multiplier LSB is set. The product is saturated to W bits with an
//   overflow flag, and the visible amount is gated by the output enable `ed`.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset
//   start  in   1  request pulse, only honoured while idle
//   rate   in   W  unsigned multiplicand (per-unit tariff)
//   units  in   M  unsigned multiplier (unit count)
//   ed     in   1  output enable; 0 forces amount to zero
//   busy   out  1  high while an operation is running
//   done   out  1  one-cycle pulse when a new result is registered
//   amount out  W  saturated product, gated by ed, held until next result
//   ovf    out  1  product exceeded 2^W-1, held with the result (not gated)
// -----------------------------------------------------------------------------
module lshift_bill_mul #(
   parameter int W = 13,
   parameter int M = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] rate,
   input  logic [M-1:0] units,
   input  logic         ed,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] amount,
   output logic         ovf
);

   localparam int AW = W + M;
   localparam int CW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   mcand_q, mcand_d;
   logic [M-1:0]    mplr_q,  mplr_d;
   logic [AW-1:0]   acc_q,   acc_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [W-1:0]    result_q, result_d;
   logic            ovf_q,   ovf_d;
   logic            done_q,  done_d;
   logic            busy_q,  busy_d;

   logic [AW-1:0]   addend_s;
   logic [AW-1:0]   sum_s;
   logic            sat_s;

   // Partial-product adder; the accumulator is wide enough that this never wraps.
   always_comb begin
      addend_s = mplr_q[0] ? mcand_q : {AW{1'b0}};
      sum_s    = acc_q + addend_s;
      sat_s    = |sum_s[AW-1:W];
   end

   // Next-state logic for the IDLE/RUN sequencer and its datapath registers.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = {{M{1'b0}}, rate};
               mplr_d  = units;
               acc_d   = {AW{1'b0}};
               cnt_d   = {CW{1'b0}};
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d   = sum_s;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            // Last iteration: the sum already includes this cycle's partial product.
            if (cnt_q == CW'(M - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (sat_s) begin
                  result_d = {W{1'b1}};
                  ovf_d    = 1'b1;
               end else begin
                  result_d = sum_s[W-1:0];
                  ovf_d    = 1'b0;
               end
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
   end

   // State and datapath registers; reset aborts any operation and clears the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= {AW{1'b0}};
         mplr_q   <= {M{1'b0}};
         acc_q    <= {AW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         result_q <= {W{1'b0}};
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   // The enable gates the visible amount only; overflow and sequencing are unaffected.
   assign amount = result_q & {W{ed}};
   assign ovf    = ovf_q;
   assign done   = done_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_lshift_bill_mul.sv
module tb_lshift_bill_mul;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [12:0] rate;
   logic [6:0]  units;
   logic        ed;
   logic        busy;
   logic        done;
   logic [12:0] amount;
   logic        ovf;

   int vectors     = 0;
   int miscompares = 0;

   // scoreboard entries: {ovf, amount}
   logic [13:0] exp_q[$];

   lshift_bill_mul #(.W(13), .M(7)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .rate   (rate),
      .units  (units),
      .ed     (ed),
      .busy   (busy),
      .done   (done),
      .amount (amount),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // drive a start pulse and queue the expected saturated product
   task automatic launch(input int r, input int u);
      int p;
      rate  = 13'(r);
      units = 7'(u);
      start = 1'b1;
      p = r * u;
      if (p > 8191) exp_q.push_back({1'b1, 13'd8191});
      else          exp_q.push_back({1'b0, 13'(p)});
      tick();
      start = 1'b0;
   endtask

   // s0 = number of samples already taken since the start edge
   task automatic wait_done(input string tag, input int s0);
      logic [13:0] e;
      bit seen;
      seen = 1'b0;
      for (int s = s0; s < s0 + 20 && !seen; s++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            check({tag, " latency"}, s, 7);
            check({tag, " busy_at_done"}, busy, 0);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check({tag, " amount"}, amount, ed ? e[12:0] : 13'd0);
               check({tag, " ovf"}, ovf, e[13]);
            end else begin
               vectors++;
               miscompares++;
               $error("FAIL %s unexpected_done: observed done=1, expected no pending result", tag);
            end
         end else begin
            tick();
         end
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $error("FAIL %s done_timeout: observed no done, expected done within 20 cycles", tag);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      ed    = 1'b1;
      rate  = 13'd0;
      units = 7'd0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset amount", amount, 0);
      check("reset ovf", ovf, 0);

      // basic product
      launch(25, 12);
      check("t1 busy", busy, 1);
      wait_done("t1", 0);
      tick();
      check("t1 done_pulse", done, 0);
      check("t1 hold", amount, 300);

      // enable gating of a held result
      ed = 1'b0;
      #1;
      check("t5 gated", amount, 0);
      check("t5 ovf_ungated", ovf, 0);
      ed = 1'b1;
      #1;
      check("t5 ungated", amount, 300);
      ed = 1'b0;
      launch(3, 4);
      check("t5 busy_ed0", busy, 1);
      wait_done("t5 ed0", 0);
      ed = 1'b1;
      #1;
      check("t5 reenabled", amount, 12);
      tick();

      // zero operands: no early termination
      launch(8191, 0);
      wait_done("t2 units0", 0);
      tick();
      launch(0, 127);
      wait_done("t2 rate0", 0);
      tick();

      // boundary and saturation
      launch(8191, 1);
      wait_done("t3 max_exact", 0);
      tick();
      launch(4096, 2);
      wait_done("t3 sat_min", 0);
      tick();
      launch(8191, 127);
      wait_done("t3 sat_max", 0);
      tick();

      // start while busy is ignored; start on the done cycle is accepted
      launch(100, 5);
      rate  = 13'd7;
      units = 7'd3;
      start = 1'b1;
      tick();
      tick();
      tick();
      start = 1'b0;
      wait_done("t4 first", 3);
      launch(7, 3);
      wait_done("t4 second", 0);
      tick();
      check("t4 done_pulse", done, 0);

      // reset mid-run aborts with no done
      launch(4096, 2);
      wait_done("t6 pre", 0);
      tick();
      launch(50, 3);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check("t6 busy", busy, 0);
      check("t6 done", done, 0);
      check("t6 amount", amount, 0);
      check("t6 ovf", ovf, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t6 no_done", done, 0);
      end
      launch(9, 9);
      wait_done("t6 after", 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
